// File: rtl/lsu_arb_pkg.sv
// Shared types and funct3 encodings for the two-master LSU arbiter.
package lsu_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Two-input picker: combinational grant, pointer remembers the last winner.
module rr_arb2 #(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_gnt0,
    output logic o_gnt1
);

    // 1 means master 1 won the last transfer, so master 0 wins the next tie.
    logic last_q;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            if ((PRIO_FIXED != 0) || last_q) begin
                o_gnt0 = 1'b1;
            end else begin
                o_gnt1 = 1'b1;
            end
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else if (i_update) begin
            last_q <= o_gnt1;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates two load/store masters onto one LSU; one access per two cycles.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_valid,
    input  logic        i_m1_valid,
    input  logic        i_m0_wren,
    input  logic        i_m1_wren,
    input  logic [2:0]  i_m0_func3,
    input  logic [2:0]  i_m1_func3,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m0_ready,
    output logic        o_m1_ready,
    output logic        o_m0_rsp_valid,
    output logic        o_m1_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_st_data,
    output logic [2:0]  o_lsu_func3,
    output logic        o_lsu_wren,
    input  logic [31:0] i_lsu_ld_data
);

    lsu_state_e  state_q;
    logic        gnt0, gnt1, xfer, req_err;
    logic        sel_wren;
    logic [2:0]  sel_func3;
    logic [31:0] sel_addr, sel_wdata;

    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  func3_q;
    logic        wren_q, err_q, owner_q;
    logic        lsu_wren_q, rsp_v0_q, rsp_v1_q, rsp_err_q;

    // Requests are arbitrated every cycle; the pointer only moves on a transfer.
    rr_arb2 #(
        .PRIO_FIXED(PRIO_FIXED)
    ) u_rr_arb2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req0   (i_m0_valid),
        .i_req1   (i_m1_valid),
        .i_update (xfer),
        .o_gnt0   (gnt0),
        .o_gnt1   (gnt1)
    );

    assign o_m0_ready = (state_q == IDLE) && gnt0;
    assign o_m1_ready = (state_q == IDLE) && gnt1;
    assign xfer       = o_m0_ready || o_m1_ready;

    assign sel_wren  = gnt1 ? i_m1_wren  : i_m0_wren;
    assign sel_func3 = gnt1 ? i_m1_func3 : i_m0_func3;
    assign sel_addr  = gnt1 ? i_m1_addr  : i_m0_addr;
    assign sel_wdata = gnt1 ? i_m1_wdata : i_m0_wdata;

    always_comb begin
        req_err = 1'b0;
        case (sel_func3)
            LB, LBU: req_err = 1'b0;
            LH, LHU: req_err = sel_addr[0];
            LW:      req_err = |sel_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            func3_q    <= '0;
            wren_q     <= 1'b0;
            err_q      <= 1'b0;
            owner_q    <= 1'b0;
            rdata_q    <= '0;
            lsu_wren_q <= 1'b0;
            rsp_v0_q   <= 1'b0;
            rsp_v1_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            lsu_wren_q <= 1'b0;
            rsp_v0_q   <= 1'b0;
            rsp_v1_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        func3_q    <= sel_func3;
                        wren_q     <= sel_wren;
                        err_q      <= req_err;
                        owner_q    <= gnt1;
                        lsu_wren_q <= sel_wren && !req_err;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!wren_q && !err_q) begin
                        rdata_q <= i_lsu_ld_data;
                    end
                    rsp_err_q <= err_q;
                    rsp_v0_q  <= !owner_q;
                    rsp_v1_q  <= owner_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_lsu_addr     = addr_q;
    assign o_lsu_st_data  = wdata_q;
    assign o_lsu_func3    = func3_q;
    assign o_lsu_wren     = lsu_wren_q;
    assign o_rsp_rdata    = rdata_q;
    assign o_rsp_err      = rsp_err_q;
    assign o_m0_rsp_valid = rsp_v0_q;
    assign o_m1_rsp_valid = rsp_v1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: one round-robin and one fixed-priority instance.
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    typedef struct packed {
        logic        owner;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        m;
        logic        wr;
        logic [2:0]  f;
        logic [31:0] a;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid, m0_wren, m1_wren;
    logic [2:0]  m0_func3, m1_func3;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    logic        r_m0_ready, r_m1_ready, r_m0_rsp, r_m1_rsp, r_err, r_lsu_wren;
    logic [31:0] r_rdata, r_lsu_addr, r_lsu_st_data, r_ld_data;
    logic [2:0]  r_lsu_func3;
    logic        f_m0_ready, f_m1_ready, f_m0_rsp, f_m1_rsp, f_err, f_lsu_wren;
    logic [31:0] f_rdata, f_lsu_addr, f_lsu_st_data, f_ld_data;
    logic [2:0]  f_lsu_func3;

    exp_t        r_q[$];
    exp_t        f_q[$];
    exp_t        rm, fm;
    logic [31:0] r_last, f_last;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] lsu_model(input logic [31:0] a);
        return (a == 32'h2000) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    function automatic logic model_err(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return (a[1:0] != 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

    function automatic exp_t predict(input logic owner, input logic wr, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] last);
        exp_t e;
        e.owner = owner;
        e.err   = model_err(f, a);
        e.rdata = (!wr && !e.err) ? lsu_model(a) : last;
        return e;
    endfunction

    assign r_ld_data = lsu_model(r_lsu_addr);
    assign f_ld_data = lsu_model(f_lsu_addr);

    lsu_arbiter #(.PRIO_FIXED(0)) u_dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_valid(m0_valid), .i_m1_valid(m1_valid),
        .i_m0_wren(m0_wren), .i_m1_wren(m1_wren),
        .i_m0_func3(m0_func3), .i_m1_func3(m1_func3),
        .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
        .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
        .o_m0_ready(r_m0_ready), .o_m1_ready(r_m1_ready),
        .o_m0_rsp_valid(r_m0_rsp), .o_m1_rsp_valid(r_m1_rsp),
        .o_rsp_rdata(r_rdata), .o_rsp_err(r_err),
        .o_lsu_addr(r_lsu_addr), .o_lsu_st_data(r_lsu_st_data),
        .o_lsu_func3(r_lsu_func3), .o_lsu_wren(r_lsu_wren),
        .i_lsu_ld_data(r_ld_data)
    );

    lsu_arbiter #(.PRIO_FIXED(1)) u_dut_fixed (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_valid(m0_valid), .i_m1_valid(m1_valid),
        .i_m0_wren(m0_wren), .i_m1_wren(m1_wren),
        .i_m0_func3(m0_func3), .i_m1_func3(m1_func3),
        .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
        .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
        .o_m0_ready(f_m0_ready), .o_m1_ready(f_m1_ready),
        .o_m0_rsp_valid(f_m0_rsp), .o_m1_rsp_valid(f_m1_rsp),
        .o_rsp_rdata(f_rdata), .o_rsp_err(f_err),
        .o_lsu_addr(f_lsu_addr), .o_lsu_st_data(f_lsu_st_data),
        .o_lsu_func3(f_lsu_func3), .o_lsu_wren(f_lsu_wren),
        .i_lsu_ld_data(f_ld_data)
    );

    // Push the predicted response for every handshake seen at the clock edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (r_m0_ready && m0_valid) begin
                rm = predict(1'b0, m0_wren, m0_func3, m0_addr, r_last);
                r_q.push_back(rm);
                r_last = rm.rdata;
            end else if (r_m1_ready && m1_valid) begin
                rm = predict(1'b1, m1_wren, m1_func3, m1_addr, r_last);
                r_q.push_back(rm);
                r_last = rm.rdata;
            end
            if (f_m0_ready && m0_valid) begin
                fm = predict(1'b0, m0_wren, m0_func3, m0_addr, f_last);
                f_q.push_back(fm);
                f_last = fm.rdata;
            end else if (f_m1_ready && m1_valid) begin
                fm = predict(1'b1, m1_wren, m1_func3, m1_addr, f_last);
                f_q.push_back(fm);
                f_last = fm.rdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs;
        m0_valid = 1'b0; m0_wren = 1'b0; m0_func3 = 3'b000; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_wren = 1'b0; m1_func3 = 3'b000; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        r_q.delete();
        f_q.delete();
        r_last = '0;
        f_last = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        r_last = '0;
        f_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({r_m0_rsp, r_m1_rsp, r_lsu_wren, r_err} !== 4'b0) begin
            errors++; $display("FAIL reset_rr_flags: got %b want 0000",
                               {r_m0_rsp, r_m1_rsp, r_lsu_wren, r_err}); end
        checks++; if ({f_m0_rsp, f_m1_rsp, f_lsu_wren, f_err} !== 4'b0) begin
            errors++; $display("FAIL reset_fx_flags: got %b want 0000",
                               {f_m0_rsp, f_m1_rsp, f_lsu_wren, f_err}); end
        checks++; if (r_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", r_rdata); end
        checks++; if (r_lsu_addr !== 32'h0 || r_lsu_st_data !== 32'h0) begin
            errors++; $display("FAIL reset_lsu_bus: got %h/%h want 0/0", r_lsu_addr,
                               r_lsu_st_data); end
        checks++; if (r_lsu_func3 !== 3'b000) begin
            errors++; $display("FAIL reset_func3: got %b want 000", r_lsu_func3); end
        checks++; if (f_rdata !== 32'h0 || f_lsu_addr !== 32'h0) begin
            errors++; $display("FAIL reset_fx_regs: got %h/%h want 0/0", f_rdata, f_lsu_addr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_load;
        exp_t e;
        m0_valid = 1'b1; m0_wren = 1'b0; m0_func3 = LW; m0_addr = 32'h2000;
        m0_wdata = 32'h1111_1111;
        @(negedge clk);
        checks++; if ({r_m0_ready, r_m1_ready} !== 2'b10) begin
            errors++; $display("FAIL load_grant: got %b want 10", {r_m0_ready, r_m1_ready}); end
        @(posedge clk); #1 m0_valid = 1'b0;
        @(negedge clk);
        checks++; if (r_lsu_wren !== 1'b0 || r_lsu_addr !== 32'h2000 || r_lsu_func3 !== LW) begin
            errors++; $display("FAIL load_access: got wren=%b addr=%h f3=%b want 0/2000/010",
                               r_lsu_wren, r_lsu_addr, r_lsu_func3); end
        @(posedge clk);
        @(negedge clk);
        checks++; if ({r_m0_rsp, r_m1_rsp} !== 2'b10) begin
            errors++; $display("FAIL load_rsp: got %b want 10", {r_m0_rsp, r_m1_rsp}); end
        checks++;
        if (r_q.size() == 0) begin
            errors++; $display("FAIL load_scoreboard: got empty queue want one entry");
        end else begin
            e = r_q.pop_front();
            if (r_rdata !== e.rdata || r_err !== e.err) begin
                errors++; $display("FAIL load_data: got %h err=%b want %h err=%b",
                                   r_rdata, r_err, e.rdata, e.err); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rr_stores;
        exp_t e;
        logic rsp_exp;
        do_reset();
        m0_wren = 1'b1; m0_func3 = LW; m0_addr = 32'h2000; m0_wdata = 32'hA0A0_0001;
        m1_wren = 1'b1; m1_func3 = LW; m1_addr = 32'h2004; m1_wdata = 32'hB1B1_0002;
        for (int i = 0; i < 10; i++) begin
            m0_valid = (i < 8);
            m1_valid = (i < 8);
            @(negedge clk);
            checks++;
            if (r_m0_ready !== (i < 8 && i % 2 == 0 && (i / 2) % 2 == 0) ||
                r_m1_ready !== (i < 8 && i % 2 == 0 && (i / 2) % 2 == 1)) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b%b", i, r_m0_ready, r_m1_ready); end
            checks++; if (r_lsu_wren !== (i % 2 == 1 && i < 8)) begin
                errors++; $display("FAIL rr_wren[%0d]: got %b want %b", i, r_lsu_wren,
                                   (i % 2 == 1 && i < 8)); end
            if (i % 2 == 1 && i < 8) begin
                checks++;
                if (r_lsu_st_data !== (((i - 1) / 2) % 2 == 1 ? m1_wdata : m0_wdata)) begin
                    errors++; $display("FAIL rr_st_data[%0d]: got %h", i, r_lsu_st_data); end
            end
            rsp_exp = (i % 2 == 0 && i >= 2 && i <= 8);
            checks++; if ((r_m0_rsp | r_m1_rsp) !== rsp_exp) begin
                errors++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, r_m0_rsp | r_m1_rsp,
                                   rsp_exp); end
            if (rsp_exp && r_q.size() != 0) begin
                e = r_q.pop_front();
                checks++; if (r_m1_rsp !== e.owner || r_err !== e.err || r_rdata !== e.rdata) begin
                    errors++; $display("FAIL rr_rsp_data[%0d]: got own=%b err=%b d=%h want %b %b %h",
                                       i, r_m1_rsp, r_err, r_rdata, e.owner, e.err, e.rdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fixed_prio;
        exp_t e;
        logic rsp_exp;
        do_reset();
        m0_wren = 1'b1; m0_func3 = LW; m0_addr = 32'h2000; m0_wdata = 32'hA0A0_0003;
        m1_wren = 1'b1; m1_func3 = LW; m1_addr = 32'h2004; m1_wdata = 32'hB1B1_0004;
        for (int i = 0; i < 10; i++) begin
            m0_valid = (i < 6);
            m1_valid = (i < 7);
            @(negedge clk);
            checks++;
            if (f_m0_ready !== (i < 6 && i % 2 == 0) || f_m1_ready !== (i == 6)) begin
                errors++; $display("FAIL fixed_grant[%0d]: got %b%b", i, f_m0_ready, f_m1_ready); end
            rsp_exp = (i % 2 == 0 && i >= 2 && i <= 8);
            checks++; if ((f_m0_rsp | f_m1_rsp) !== rsp_exp) begin
                errors++; $display("FAIL fixed_rsp[%0d]: got %b want %b", i, f_m0_rsp | f_m1_rsp,
                                   rsp_exp); end
            if (rsp_exp && f_q.size() != 0) begin
                e = f_q.pop_front();
                checks++; if (f_m1_rsp !== e.owner || f_rdata !== e.rdata) begin
                    errors++; $display("FAIL fixed_owner[%0d]: got %b %h want %b %h", i, f_m1_rsp,
                                       f_rdata, e.owner, e.rdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors;
        vec_t tab[7];
        exp_t e;
        tab[0] = '{m: 1'b1, wr: 1'b1, f: 3'b010, a: 32'h2002};
        tab[1] = '{m: 1'b0, wr: 1'b0, f: 3'b011, a: 32'h2000};
        tab[2] = '{m: 1'b0, wr: 1'b0, f: 3'b101, a: 32'h2001};
        tab[3] = '{m: 1'b0, wr: 1'b0, f: 3'b001, a: 32'h2002};
        tab[4] = '{m: 1'b1, wr: 1'b0, f: 3'b000, a: 32'h2003};
        tab[5] = '{m: 1'b0, wr: 1'b1, f: 3'b010, a: 32'h2004};
        tab[6] = '{m: 1'b1, wr: 1'b0, f: 3'b110, a: 32'h2000};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (tab[k].m) begin
                m1_valid = 1'b1; m1_wren = tab[k].wr; m1_func3 = tab[k].f; m1_addr = tab[k].a;
                m1_wdata = 32'hC0DE_0000 + k;
            end else begin
                m0_valid = 1'b1; m0_wren = tab[k].wr; m0_func3 = tab[k].f; m0_addr = tab[k].a;
                m0_wdata = 32'hC0DE_0000 + k;
            end
            @(negedge clk);
            checks++; if ((tab[k].m ? r_m1_ready : r_m0_ready) !== 1'b1) begin
                errors++; $display("FAIL err_grant[%0d]: got 0 want 1", k); end
            @(posedge clk); #1 m0_valid = 1'b0; m1_valid = 1'b0;
            @(negedge clk);
            checks++; if (r_lsu_wren !== (tab[k].wr && !model_err(tab[k].f, tab[k].a))) begin
                errors++; $display("FAIL err_wren[%0d]: got %b", k, r_lsu_wren); end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (r_q.size() == 0) begin
                errors++; $display("FAIL err_scoreboard[%0d]: got empty queue", k);
            end else begin
                e = r_q.pop_front();
                if ({r_m1_rsp, r_m0_rsp} !== {e.owner, !e.owner} || r_err !== e.err ||
                    r_rdata !== e.rdata) begin
                    errors++; $display("FAIL err_rsp[%0d]: got rsp=%b%b err=%b d=%h want own=%b err=%b d=%h",
                                       k, r_m1_rsp, r_m0_rsp, r_err, r_rdata, e.owner, e.err, e.rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        do_reset();
        m0_valid = 1'b1; m0_wren = 1'b1; m0_func3 = LW; m0_addr = 32'h2000;
        m0_wdata = 32'h5555_AAAA;
        @(negedge clk);
        @(posedge clk); #1 m0_valid = 1'b0;
        @(negedge clk);
        checks++; if (r_lsu_wren !== 1'b1) begin
            errors++; $display("FAIL abort_wren_before: got %b want 1", r_lsu_wren); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (r_lsu_wren !== 1'b0 || r_lsu_addr !== 32'h0) begin
            errors++; $display("FAIL abort_wren_drop: got %b addr=%h want 0/0", r_lsu_wren,
                               r_lsu_addr); end
        @(posedge clk);
        r_q.delete(); f_q.delete(); r_last = '0; f_last = '0;
        #1;
        m0_valid = 1'b1; m0_wren = 1'b0; m0_func3 = LW; m0_addr = 32'h2010;
        m1_valid = 1'b1; m1_wren = 1'b0; m1_func3 = LW; m1_addr = 32'h2014;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({r_m0_rsp, r_m1_rsp} !== 2'b00) begin
            errors++; $display("FAIL abort_no_rsp: got %b want 00", {r_m0_rsp, r_m1_rsp}); end
        checks++; if ({r_m0_ready, r_m1_ready} !== 2'b10) begin
            errors++; $display("FAIL abort_first_tie: got %b want 10", {r_m0_ready, r_m1_ready}); end
        @(posedge clk); #1 m0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({r_m0_rsp, r_m1_ready} !== 2'b11) begin
            errors++; $display("FAIL abort_m0_rsp: got %b want 11", {r_m0_rsp, r_m1_ready}); end
        if (r_q.size() != 0) begin
            e = r_q.pop_front();
            checks++; if (r_rdata !== e.rdata) begin
                errors++; $display("FAIL abort_m0_data: got %h want %h", r_rdata, e.rdata); end
        end
        @(posedge clk); #1 m1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (r_m1_rsp !== 1'b1) begin
            errors++; $display("FAIL abort_m1_rsp: got %b want 1", r_m1_rsp); end
        if (r_q.size() != 0) begin
            e = r_q.pop_front();
            checks++; if (r_rdata !== e.rdata) begin
                errors++; $display("FAIL abort_m1_data: got %h want %h", r_rdata, e.rdata); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [31:0] prev;
        do_reset();
        prev = '0;
        m0_valid = 1'b1; m0_wren = 1'b0; m0_func3 = LW; m0_addr = 32'h2008;
        @(negedge clk);
        @(posedge clk); #1 m0_valid = 1'b0;
        @(posedge clk); #1;
        m0_valid = 1'b1; m0_addr = 32'h200C;
        @(negedge clk);
        checks++; if ({r_m0_rsp, r_m0_ready} !== 2'b11) begin
            errors++; $display("FAIL b2b_same_cycle: got rsp/ready=%b want 11",
                               {r_m0_rsp, r_m0_ready}); end
        if (r_q.size() != 0) begin
            e = r_q.pop_front();
            prev = e.rdata;
            checks++; if (r_rdata !== e.rdata) begin
                errors++; $display("FAIL b2b_first_data: got %h want %h", r_rdata, e.rdata); end
        end
        @(posedge clk); #1 m0_valid = 1'b0;
        @(negedge clk);
        checks++; if (r_rdata !== prev) begin
            errors++; $display("FAIL b2b_hold: got %h want %h", r_rdata, prev); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (r_q.size() == 0) begin
            errors++; $display("FAIL b2b_scoreboard: got empty queue");
        end else begin
            e = r_q.pop_front();
            if (r_m0_rsp !== 1'b1 || r_rdata !== e.rdata) begin
                errors++; $display("FAIL b2b_second: got rsp=%b d=%h want 1 %h", r_m0_rsp,
                                   r_rdata, e.rdata); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_rr_stores();
        test_fixed_prio();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        checks++; if (r_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left want 0", r_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
